// File: rtl/tod_bcd_clock.sv
// 24 h BCD time-of-day counter with prescaled seconds, field adjust and day/night flag.
// Optional macro TOD_FAST_FWD_EN adds a fast_fwd input that advances time one second per clk in RUN.
module tod_bcd_clock #(
    parameter int unsigned TICKS_PER_SEC  = 100,
    parameter logic [7:0]  DAY_START_HR   = 8'h08,
    parameter logic [7:0]  NIGHT_START_HR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] adj_mode,
    input  logic       adj_inc,
`ifdef TOD_FAST_FWD_EN
    input  logic       fast_fwd,
`endif
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       d_or_n,
    output logic       sec_tick,
    output logic       day_tick
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam logic [15:0] TERM_CNT = 16'(TICKS_PER_SEC - 1);

    state_t      state;
    logic [15:0] presc;
    logic [15:0] presc_nx;
    logic [7:0]  hour_nx;
    logic [7:0]  min_nx;
    logic [7:0]  sec_nx;
    logic        adv;
    logic        wrap_day;
    logic        fast;

`ifdef TOD_FAST_FWD_EN
    assign fast = fast_fwd;
`else
    assign fast = 1'b0;
`endif

    // Increment a two-digit BCD value, wrapping to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        hour_nx  = hour;
        min_nx   = min;
        sec_nx   = sec;
        presc_nx = presc;
        adv      = 1'b0;
        wrap_day = 1'b0;
        case (state)
            RUN: begin
                if (fast || presc == TERM_CNT) begin
                    adv      = 1'b1;
                    presc_nx = 16'd0;
                end else begin
                    presc_nx = presc + 16'd1;
                end
            end
            SET_HOUR: begin
                presc_nx = 16'd0;
                if (adj_inc) hour_nx = bcd_inc(hour, 8'h23);
            end
            SET_MIN: begin
                presc_nx = 16'd0;
                if (adj_inc) min_nx = bcd_inc(min, 8'h59);
            end
            SET_SEC: begin
                presc_nx = 16'd0;
                if (adj_inc) sec_nx = 8'h00;
            end
            default: presc_nx = 16'd0;
        endcase
        // Seconds ripple into minutes and hours only on a RUN-mode advance.
        if (adv) begin
            sec_nx = bcd_inc(sec, 8'h59);
            if (sec == 8'h59) begin
                min_nx = bcd_inc(min, 8'h59);
                if (min == 8'h59) begin
                    hour_nx  = bcd_inc(hour, 8'h23);
                    wrap_day = (hour == 8'h23);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            presc    <= 16'd0;
            hour     <= 8'h00;
            min      <= 8'h00;
            sec      <= 8'h00;
            d_or_n   <= 1'b1;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
        end else begin
            state    <= state_t'(adj_mode);
            presc    <= presc_nx;
            hour     <= hour_nx;
            min      <= min_nx;
            sec      <= sec_nx;
            d_or_n   <= (hour_nx < DAY_START_HR) || (hour_nx >= NIGHT_START_HR);
            sec_tick <= adv;
            day_tick <= wrap_day;
        end
    end

endmodule

// File: tb/tb_tod_bcd_clock.sv
// Bench for tod_bcd_clock: seconds-of-day reference model checked every cycle, directed scenarios and random stimulus.
module tb_tod_bcd_clock;

    localparam int T       = 4;
    localparam int DAY_H   = 8;
    localparam int NIGHT_H = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] adj_mode = 2'b00;
    logic       adj_inc = 1'b0;
    logic       fast_fwd = 1'b0;
    logic [7:0] hour, min, sec;
    logic       d_or_n, sec_tick, day_tick;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: plain decimal fields and cycles-in-RUN counter.
    int m_h = 0, m_m = 0, m_s = 0, m_cnt = 0, m_state = 0;
    bit m_st = 1'b0, m_dt = 1'b0;

    tod_bcd_clock #(.TICKS_PER_SEC(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .adj_mode (adj_mode),
        .adj_inc  (adj_inc),
`ifdef TOD_FAST_FWD_EN
        .fast_fwd (fast_fwd),
`endif
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .d_or_n   (d_or_n),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic night(input int h);
        return (h < DAY_H) || (h >= NIGHT_H);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  t;
        bit  adv;
        bit  ff;
`ifdef TOD_FAST_FWD_EN
        ff = fast_fwd;
`else
        ff = 1'b0;
`endif
        m_st = 1'b0;
        m_dt = 1'b0;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_state = 0;
        end else begin
            case (m_state)
                0: begin
                    adv = 1'b0;
                    if (ff) begin
                        adv = 1'b1;
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == T) begin
                            adv = 1'b1;
                            m_cnt = 0;
                        end
                    end
                    if (adv) begin
                        t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                        m_h = t / 3600;
                        m_m = (t / 60) % 60;
                        m_s = t % 60;
                        m_st = 1'b1;
                        m_dt = (t == 0);
                    end
                end
                1: begin m_cnt = 0; if (adj_inc) m_h = (m_h + 1) % 24; end
                2: begin m_cnt = 0; if (adj_inc) m_m = (m_m + 1) % 60; end
                default: begin m_cnt = 0; if (adj_inc) m_s = 0; end
            endcase
            m_state = int'(adj_mode);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hour", hour, bcd(m_h));
            chk("min", min, bcd(m_m));
            chk("sec", sec, bcd(m_s));
            chk("d_or_n", {7'd0, d_or_n}, {7'd0, night(m_h)});
            chk("sec_tick", {7'd0, sec_tick}, {7'd0, m_st});
            chk("day_tick", {7'd0, day_tick}, {7'd0, m_dt});
        end
    end

    task automatic goto_mode(input int md);
        adj_mode = 2'(md);
        adj_inc  = 1'b0;
        step();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            adj_inc = 1'b1;
            step();
        end
        adj_inc = 1'b0;
    endtask

    // Leaves the clock frozen in SET_HOUR at h:m:59.
    task automatic preload(input int h, input int m);
        goto_mode(1);
        pulses((h - m_h + 24) % 24);
        goto_mode(2);
        pulses((m - m_m + 60) % 60);
        goto_mode(3);
        pulses(1);
        goto_mode(0);
        repeat (59 * T) step();
        goto_mode(1);
    endtask

    initial begin
        int  saved;
        bit  saw_tick;
        int  r;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_hour", hour, 8'h00);
        chk("rst_sec", sec, 8'h00);
        chk("rst_dn", {7'd0, d_or_n}, 8'h01);
        chk("rst_tick", {6'd0, sec_tick, day_tick}, 8'h00);
        rst = 1'b0;
        repeat (T - 1) step();
        chk("first_adv_early", sec, 8'h00);
        step();
        chk("first_adv", sec, 8'h01);
        chk("first_adv_tick", {7'd0, sec_tick}, 8'h01);
        chk("model_first_adv", bcd(m_s), 8'h01);

        // Hour wrap and day boundary in SET_HOUR
        goto_mode(1);
        pulses((23 - m_h + 24) % 24);
        chk("set_h23", hour, 8'h23);
        saved = m_m;
        pulses(1);
        chk("set_h_wrap", hour, 8'h00);
        chk("set_h_min_keep", min, bcd(saved));
        pulses(7);
        chk("set_h07", hour, 8'h07);
        chk("dn_07", {7'd0, d_or_n}, 8'h01);
        pulses(1);
        chk("set_h08", hour, 8'h08);
        chk("dn_08", {7'd0, d_or_n}, 8'h00);

        // Midnight rollover
        preload(23, 59);
        chk("pre_2359", sec, 8'h59);
        goto_mode(0);
        repeat (T - 1) step();
        chk("pre_roll_sec", sec, 8'h59);
        step();
        chk("roll_h", hour, 8'h00);
        chk("roll_m", min, 8'h00);
        chk("roll_s", sec, 8'h00);
        chk("roll_ticks", {6'd0, sec_tick, day_tick}, 8'h03);
        chk("roll_dn", {7'd0, d_or_n}, 8'h01);
        step();
        chk("roll_ticks_off", {6'd0, sec_tick, day_tick}, 8'h00);

        // Hour ones carry and night entry
        preload(19, 59);
        chk("dn_19", {7'd0, d_or_n}, 8'h00);
        goto_mode(0);
        repeat (T) step();
        chk("h19_20", hour, 8'h20);
        chk("h19_20_ms", {min[3:0], sec[3:0]}, 8'h00);
        chk("dn_20", {7'd0, d_or_n}, 8'h01);
        preload(9, 9);
        goto_mode(0);
        repeat (T) step();
        chk("m09_10", min, 8'h10);
        chk("m09_10_h", hour, 8'h09);
        chk("m09_10_s", sec, 8'h00);

        // Held increment in SET_MIN
        goto_mode(2);
        pulses((60 - m_m) % 60);
        saved = m_h;
        saw_tick = 1'b0;
        adj_inc = 1'b1;
        for (int i = 0; i < 61; i++) begin
            step();
            if (sec_tick) saw_tick = 1'b1;
        end
        adj_inc = 1'b0;
        chk("hold_min", min, 8'h01);
        chk("hold_hour", hour, bcd(saved));
        chk("hold_no_tick", {7'd0, saw_tick}, 8'h00);

`ifdef TOD_FAST_FWD_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        fast_fwd = 1'b1;
        repeat (60) step();
        chk("ff_min", min, 8'h01);
        chk("ff_sec", sec, 8'h00);
        rst = 1'b1;
        step();
        chk("ff_rst_min", min, 8'h00);
        rst = 1'b0;
        fast_fwd = 1'b0;
`endif

        // Random stimulus against the model
        goto_mode(0);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            rst = (r < 3);
            if ($urandom_range(0, 24) == 0)
                adj_mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            adj_inc = ($urandom_range(0, 2) == 0);
`ifdef TOD_FAST_FWD_EN
            if ($urandom_range(0, 15) == 0) fast_fwd = ~fast_fwd;
`endif
            step();
        end
        rst = 1'b0;
        adj_inc = 1'b0;
        step();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
